mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit words stored.
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the wait states inserted before each response; legal range is 0-15.
REQ-003 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 i_req  in  1  instruction-fetch request, held high by the initiator until i_ready.
REQ-006 i_addr  in  32  instruction byte address.
REQ-007 i_ready  out  1  one-cycle pulse that completes a fetch.
REQ-008 i_rdata  out  32  fetched word, valid only while i_ready=1.
REQ-009 i_err  out  1  fetch error flag, valid only while i_ready=1.
REQ-010 d_req  in  1  data request, held high until d_ready.
REQ-011 d_we  in  1  1=store, 0=load; sampled at acceptance.
REQ-012 d_addr  in  32  data byte address.
REQ-013 d_wdata  in  32  store data; sampled at acceptance.
REQ-014 d_ready  out  1  one-cycle pulse that completes a data access.
REQ-015 d_rdata  out  32  load data, valid only while d_ready=1.
REQ-016 d_err  out  1  data error flag, valid only while d_ready=1.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-018 IDLE: when any request is high at an edge, the block SHALL latch the granted port, address, we and wdata.
REQ-019 From IDLE, the FSM SHALL go to WAIT with counter=WAIT_CYCLES-1, or go directly to RESP when WAIT_CYCLES=0.
REQ-020 WAIT SHALL decrement the counter each cycle and SHALL go to RESP on the edge where the counter is 0.
REQ-021 RESP SHALL last exactly one cycle, drive the granted port's ready=1, then return to IDLE.
REQ-022 Latency: ready SHALL be high in cycle k+WAIT_CYCLES+1, where k is the accepting edge.
REQ-023 Back-to-back: the next acceptance SHALL occur no earlier than the first edge after the RESP cycle.
REQ-024 Arbitration: with a single request, that port SHALL be granted.
REQ-025 With both requests high in IDLE, the port not granted last SHALL win; after reset, last-granted SHALL be instruction, so data wins the first tie.
REQ-026 Word index SHALL be addr[31:2].
REQ-027 An access with addr[1:0]!=0 or word index >= DEPTH_WORDS SHALL be an error.
REQ-028 An error access SHALL return err=1 with ready, return rdata=0, and perform no store.
REQ-029 A store SHALL commit to the array on the edge entering RESP.
REQ-030 A store response SHALL return d_rdata=0.
REQ-031 A load SHALL return the array word as it stood on the edge entering RESP, including stores committed earlier.
REQ-032 A request dropped after acceptance SHALL NOT abort the transaction: the access completes, a store still commits, and ready still pulses.
REQ-033 Outside RESP, all ready, err and rdata outputs SHALL be 0.
REQ-034 Address and data inputs SHALL be ignored outside acceptance.

Reset
REQ-035 While reset=0, state SHALL be IDLE, the counter 0, and last-granted=instruction.
REQ-036 While reset=0, all outputs SHALL be 0.
REQ-037 Reset asserted mid-transaction SHALL abandon that transaction without a response.
REQ-038 A store whose commit edge has not yet occurred when reset asserts SHALL NOT be written.
REQ-039 The storage array SHALL NOT be cleared by reset.

Structure
REQ-040 Package mem_pkg SHALL hold the state encoding (IDLE/WAIT/RESP), the port-ID constants (PORT_I, PORT_D) and the word/byte-width constants.
REQ-041 Storage SHALL be a sub-module mem_array: DEPTH_WORDS x 32, synchronous write, combinational read, no reset.
REQ-042 The FSM, arbiter and counter SHALL live in mem_responder.

Verification (WAIT_CYCLES=2 unless noted)
REQ-043 Store then load: d_req/d_we=1, addr 0x10, wdata 0xDEADBEEF -> d_ready on cycle k+3 with d_err=0; a following load of 0x10 returns 0xDEADBEEF.
REQ-044 Tie arbitration: i_req and d_req rise together after reset -> data is served first (ready at k+3), then instruction (ready at k+7), and i_ready=d_ready=1 never occurs.
REQ-045 Errors: load at 0x13 -> d_err=1, d_rdata=0; store at 4*DEPTH_WORDS -> d_err=1, and a reload at 0x0 shows no change.
REQ-046 Reset mid-WAIT: assert reset during a store to 0x20 -> no ready pulse, and 0x20 keeps its old value after release.
REQ-047 WAIT_CYCLES=0: alternating i/d requests held continuously -> each ready arrives one cycle after acceptance, with grants alternating D,I,D,I.
REQ-048 Dropped request: d_req deasserted in the cycle after acceptance of a store of 0x5 to 0x8 -> d_ready still pulses, and 0x8 reads 0x5.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and types for the memory responder
package mem_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = WORD_W / BYTE_W;
    localparam int ADDR_LSB   = $clog2(WORD_BYTES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef struct packed {
        logic port;
        logic we;
        logic err;
    } req_t;

    // Misaligned or beyond the array: the access is answered with err and has no effect.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
        return (addr[ADDR_LSB-1:0] != '0) || ((addr >> ADDR_LSB) >= depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word storage, synchronous write, combinational read, never reset
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - two-port (instruction/data) memory responder with fixed wait states
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    req_t              req_q, req_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              grant;
    logic [31:0]       sel_addr;
    logic              wr_en;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] rd_word;
    logic              resp;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        req_d   = req_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;

        // On a tie the port that was not served last wins.
        if (i_req && d_req) begin
            grant = (last_q == PORT_I) ? PORT_D : PORT_I;
        end else begin
            grant = d_req ? PORT_D : PORT_I;
        end
        sel_addr = (grant == PORT_D) ? d_addr : i_addr;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    last_d    = grant;
                    req_d.port = grant;
                    req_d.we   = (grant == PORT_D) && d_we;
                    req_d.err  = addr_bad(sel_addr, DEPTH_WORDS);
                    idx_d     = sel_addr[AW+ADDR_LSB-1:ADDR_LSB];
                    wdata_d   = d_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Next-state values are used so a zero-wait store still commits on its accepting edge.
        wr_en = (state_d == ST_RESP) && (state_q != ST_RESP) && req_d.we && !req_d.err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= PORT_I;
            req_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .we   (wr_en),
        .waddr(idx_d),
        .wdata(wdata_d),
        .raddr(idx_q),
        .rdata(mem_rdata)
    );

    assign resp    = (state_q == ST_RESP);
    assign rd_word = (resp && !req_q.we && !req_q.err) ? mem_rdata : '0;

    assign i_ready = resp && (req_q.port == PORT_I);
    assign i_err   = i_ready && req_q.err;
    assign i_rdata = i_ready ? rd_word : '0;
    assign d_ready = resp && (req_q.port == PORT_D);
    assign d_err   = d_ready && req_q.err;
    assign d_rdata = d_ready ? rd_word : '0;

endmodule
